bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the multiplexed seven-segment display driver. It accepts a binary value on a start strobe and produces a packed BCD digit vector that is held stable for the display stage. Digit codes 10-15 render blank downstream; this block uses 4'hF to request a blank digit.

Parameters:
DIGITS, 4, number of BCD output digits (1..8)
WIDTH, 14, binary input width in bits (1..32)

Ports:
i_clk_10mhz  input  1  system clock
i_rst  input  1  asynchronous active-high reset
i_start  input  1  conversion request; sampled only in IDLE
i_value  input  WIDTH  unsigned binary value, captured on the accepted i_start edge
o_busy  output  1  high while a conversion is in progress
o_done  output  1  one-cycle pulse when o_digits/o_overflow update
o_digits  output  DIGITS*4  packed BCD; digit i at [4i+3:4i]; held between conversions
o_overflow  output  1  high when the last captured value was >= 10**DIGITS; held

Behaviour:
- Reset: one clock, i_clk_10mhz; reset is asynchronous and active-high on i_rst. Reset forces state IDLE, o_busy=0, o_done=0, o_overflow=0, o_digits=0, iteration counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, i_start=1 at edge N:
  - Capture i_value into the shift register; clear the BCD accumulator.
  - Counter=0; state goes to SHIFT; o_busy=1 from edge N.
  - Compute the overflow flag at capture: (i_value >= 10**DIGITS). Use a localparam sized to hold 10**DIGITS; if 2**WIDTH <= 10**DIGITS the flag is constant 0.
- SHIFT, each edge:
  - Add 3 to every accumulator digit that is >= 5.
  - Shift {accumulator, shift register} left by 1.
  - Counter increments.
  - After exactly WIDTH shifts (counter==WIDTH-1 at the edge), state goes to DONE.
  - Accumulator is DIGITS digits wide; bits shifted out of the top are discarded. The result is valid only when there is no overflow.
- DONE, one edge:
  - o_digits <= accumulator, or all digits 4'hF if overflow.
  - o_overflow <= flag; o_done <= 1; o_busy <= 0; state goes to IDLE.
- o_done is a single-cycle pulse; it is cleared on the next edge.
- Latency: start accepted at edge N; o_done is high, with new o_digits, after edge N+WIDTH+1. Throughput is one conversion per WIDTH+2 cycles.
- i_start while in SHIFT or DONE is ignored. It is not queued and has no effect on the captured value.
- i_value is only sampled at acceptance; later changes have no effect.
- o_digits and o_overflow change only at DONE edges or on reset. The display stage never sees intermediate values.
- Reset mid-conversion aborts immediately to reset values. No o_done pulse is produced for the aborted conversion.
- Back-to-back operation: i_start held high continuously is re-accepted on the first edge in IDLE, i.e. the edge after o_done asserts.

Optional Feature:
BIN2BCD_LZB_EN: leading-zero blanking.
- Defined: in the DONE state, every zero digit above the most significant nonzero digit is replaced with 4'hF. Digit 0 is never blanked, so a value of 0 shows a single "0". Overflow output is unchanged (all 4'hF).
- Undefined: digits are output as plain BCD with leading zeros.
- Latency is identical in both builds.

Test Plan:
1. Reset, then i_value=1234 with a one-cycle i_start (defaults) -> o_busy high for 15 cycles; o_done one-cycle pulse 15 cycles after start; o_digits=16'h1234; o_overflow=0.
2. i_value=0, then i_value=9999 -> o_digits=16'h0000, then 16'h9999; o_overflow=0 both times (LZB build: 16'hFFF0, then 16'h9999).
3. i_value=10000 and i_value=16383 -> o_overflow=1, o_digits=16'hFFFF; a following conversion of 42 clears o_overflow and gives 16'h0042 (LZB build: 16'hFF42).
4. Start 5678; pulse i_start with i_value=1111 at cycles 3 and 14 of the conversion -> both pulses ignored; result 16'h5678; exactly one o_done.
5. Assert i_rst at cycle 7 of converting 4321 -> outputs go to 0 immediately and asynchronously; no o_done. After release, converting 4321 gives 16'h4321.
6. Hold i_start high continuously while changing i_value 1, 22, 333 at each o_done -> conversions complete every 16 cycles with the matching BCD values.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// The result is held stable on o_digits for the seven-segment display stage, and
// code 4'hF asks that stage to blank a digit.
// Optional build macro BIN2BCD_LZB_EN enables leading-zero blanking on the result.
module bin2bcd_seq #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  i_clk_10mhz,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_value,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DIGITS*4-1:0]   o_digits,
  output logic                  o_overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = DIGITS * 4;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  // Smallest value that no longer fits in DIGITS decimal digits.
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  // If the input range never reaches LIMIT the flag folds to constant 0.
  localparam bit OVF_POSSIBLE = ((64'd1 << WIDTH) > LIMIT);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    sr_q;
  logic [AW-1:0]       acc_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;
  logic [AW-1:0]       digits_q;
  logic                ovf_out_q;

  logic                ovf_d;
  logic [AW-1:0]       acc_adj;
  logic [AW+WIDTH-1:0] shifted;
  logic [AW-1:0]       disp_d;

  assign ovf_d   = OVF_POSSIBLE && (64'(i_value) >= LIMIT);
  assign shifted = {acc_adj, sr_q} << 1;

  // Add 3 to every accumulator digit >= 5 so the next doubling carries correctly.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++)
      if (acc_q[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
  end

`ifdef BIN2BCD_LZB_EN
  logic lead;
  // Final display value: blank zeros above the top nonzero digit; digit 0 always shows.
  always_comb begin
    disp_d = acc_q;
    lead   = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (acc_q[4*d +: 4] == 4'd0)) disp_d[4*d +: 4] = 4'hF;
      else                                    lead = 1'b0;
    end
    if (ovf_q) disp_d = '1;
  end
`else
  // Final display value: plain BCD, or all blanks when the value did not fit.
  always_comb begin
    disp_d = acc_q;
    if (ovf_q) disp_d = '1;
  end
`endif

  // Control FSM plus datapath; outputs only move at DONE or on reset.
  always_ff @(posedge i_clk_10mhz or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      digits_q  <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            sr_q    <= i_value;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= ovf_d;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= shifted[AW+WIDTH-1:WIDTH];
          sr_q  <= shifted[WIDTH-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          digits_q  <= disp_d;
          ovf_out_q <= ovf_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_digits   = digits_q;
  assign o_overflow = ovf_out_q;

endmodule
